// File: rtl/int2fp_seq.sv
// Sequential signed 32-bit integer to IEEE-754 single-precision converter.
// Normalizes one bit per cycle, then rounds to nearest-even on the final edge.
module int2fp_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] vin,
    output logic [31:0] vout,
    output logic        done,
    output logic        busy,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        NORM = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic        sgn, sgn_nx;
    logic [31:0] mag, mag_nx;
    logic [7:0]  exp_r, exp_nx;
    logic [31:0] vout_nx;
    logic        done_nx;

    logic [31:0] vin_abs;
    logic        round_up;
    logic [23:0] frac_rnd;
    logic [7:0]  exp_rnd;

    // Two's-complement negation maps -2^31 onto 0x80000000, which is its magnitude.
    assign vin_abs  = vin[31] ? (~vin + 32'd1) : vin;

    // Nearest-even: guard is mag[7], sticky is mag[6:0], lsb of the fraction is mag[8].
    assign round_up = mag[7] & ((|mag[6:0]) | mag[8]);
    assign frac_rnd = {1'b0, mag[30:8]} + {23'd0, round_up};
    assign exp_rnd  = exp_r + {7'd0, frac_rnd[23]};

    always_comb begin
        state_nx = state;
        sgn_nx   = sgn;
        mag_nx   = mag;
        exp_nx   = exp_r;
        vout_nx  = vout;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (vin == 32'd0) begin
                        vout_nx = 32'd0;
                        done_nx = 1'b1;
                    end else begin
                        sgn_nx   = vin[31];
                        mag_nx   = vin_abs;
                        exp_nx   = 8'd158;
                        state_nx = NORM;
                    end
                end
            end
            NORM: begin
                if (!mag[31]) begin
                    mag_nx = {mag[30:0], 1'b0};
                    exp_nx = exp_r - 8'd1;
                end else begin
                    // On fraction overflow frac_rnd[22:0] is already zero.
                    vout_nx  = {sgn, exp_rnd, frac_rnd[22:0]};
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sgn   <= 1'b0;
            mag   <= 32'd0;
            exp_r <= 8'd0;
            vout  <= 32'd0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            sgn   <= sgn_nx;
            mag   <= mag_nx;
            exp_r <= exp_nx;
            vout  <= vout_nx;
            done  <= done_nx;
        end
    end

    assign busy      = (state == NORM);
    assign state_dbg = state;

endmodule

// File: tb/tb_int2fp_seq.sv
// Directed testbench for int2fp_seq: hand-computed floats, latency and handshake checks.
module tb_int2fp_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] vin;
    logic [31:0] vout;
    logic        done;
    logic        busy;
    logic        state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    logic [31:0] exp_q[$];

    int2fp_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vin       (vin),
        .vout      (vout),
        .done      (done),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Present one request and return just after the accepting edge.
    task automatic launch(input logic [31:0] v, input logic [31:0] want);
        @(negedge clk);
        vin   = v;
        start = 1'b1;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        t_start = cyc;
        start   = 1'b0;
    endtask

    // Wait (bounded) for done, then check latency, result and pulse width.
    task automatic wait_done(input string tag, input int exp_lat);
        logic [31:0] want;
        while (!done && (cyc - t_start) < 40) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_lat"}, 32'(cyc - t_start), 32'(exp_lat));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check({tag, "_vout"}, vout, want);
        check({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic convert(input string tag, input logic [31:0] v,
                           input logic [31:0] want, input int exp_lat);
        launch(v, want);
        if (exp_lat > 0) check({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
        wait_done(tag, exp_lat);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        vin   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vout", vout, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {31'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: tag, vin, expected float, latency = lz+1 (0 for zero)
        convert("zero",      32'h00000000, 32'h00000000, 0);
        convert("one",       32'h00000001, 32'h3F800000, 32);
        convert("neg_one",   32'hFFFFFFFF, 32'hBF800000, 32);
        convert("int_min",   32'h80000000, 32'hCF000000, 1);
        convert("int_max",   32'h7FFFFFFF, 32'h4F000000, 2);
        convert("tie_even",  32'h01000001, 32'h4B800000, 8);
        convert("tie_odd",   32'h01000003, 32'h4B800002, 8);
        convert("exact_2",   32'h01000002, 32'h4B800001, 8);
        convert("ff_24",     32'h00FFFFFF, 32'h4B7FFFFF, 9);
        convert("dec_1000",  32'd1000,     32'h447A0000, 23);
        convert("neg_tie",   32'hFEFFFFFF, 32'hCB800000, 8);
        convert("zero_b",    32'h00000000, 32'h00000000, 0);

        // start pulse and vin change mid-conversion must not disturb the result
        launch(32'h00000001, 32'h3F800000);
        repeat (4) @(negedge clk);
        start = 1'b1;
        vin   = 32'h80000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        vin   = 32'h12345678;
        check("mid_busy", {31'd0, busy}, 32'd1);
        wait_done("mid_start", 32);

        // start held through the done cycle: second request accepted back-to-back
        @(negedge clk);
        vin   = 32'h80000000;
        start = 1'b1;
        exp_q.push_back(32'hCF000000);
        @(posedge clk);
        #1;
        t_start = cyc;
        vin     = 32'h40000000;
        exp_q.push_back(32'h4E800000);
        wait_done("b2b_a", 1);
        t_start = cyc;
        start   = 1'b0;
        check("b2b_b_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b_b", 2);

        // Reset during NORM aborts with no done
        launch(32'h00000001, 32'h3F800000);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_vout", vout, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) check("abort_no_done", {31'd0, done}, 32'd0);
        end
        check("abort_idle", {31'd0, state_dbg}, 32'd0);
        convert("after_rst", 32'hFFFFFC18, 32'hC47A0000, 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
